// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined ARM-semantics barrel shifter with valid/ready handshakes
// Right-shift datapath only; LSL runs on a bit-reversed operand and is reversed back at the end.
module shift_pipe #(
   parameter int DW     = 32,
   parameter int AW     = 8,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [DW-1:0]    DIN,
   input  logic [AW-1:0]    SHAMT,
   input  logic [2:0]       MODE,
   input  logic             CIN,
   input  logic [TAG_W-1:0] IN_TAG,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [DW-1:0]    DOUT,
   output logic             COUT,
   output logic [TAG_W-1:0] OUT_TAG
);
   localparam int LW   = $clog2(DW);
   localparam int BASE = LW / STAGES;
   localparam int MID  = (STAGES > 1) ? STAGES - 1 : 1;
   localparam logic [AW-1:0] DW_A = AW'(DW);

   localparam logic [2:0] M_LSL = 3'd0;
   localparam logic [2:0] M_LSR = 3'd1;
   localparam logic [2:0] M_ASR = 3'd2;
   localparam logic [2:0] M_ROR = 3'd3;
   localparam logic [2:0] M_RRX = 3'd4;

   localparam logic [1:0] C_ZERO = 2'd0;
   localparam logic [1:0] C_LT   = 2'd1;
   localparam logic [1:0] C_EQ   = 2'd2;

   // intermediate stage registers (all but the last stage)
   logic [DW-1:0]    mw_q    [MID];
   logic [DW-1:0]    mw_d    [MID];
   logic [LW-1:0]    mamt_q  [MID];
   logic [LW-1:0]    mamt_d  [MID];
   logic [1:0]       mcls_q  [MID];
   logic [1:0]       mcls_d  [MID];
   logic [2:0]       mmode_q [MID];
   logic [2:0]       mmode_d [MID];
   logic [TAG_W-1:0] mtag_q  [MID];
   logic [TAG_W-1:0] mtag_d  [MID];
   logic [MID-1:0]   mg_q, mg_d, mfill_q, mfill_d, mrot_q, mrot_d, mcin_q, mcin_d;

   logic [STAGES-1:0] v_q, v_d, ld;
   logic [DW-1:0]     dout_q, dout_d;
   logic              cout_q, cout_d;
   logic [TAG_W-1:0]  otag_q, otag_d;

   logic             in_rdy, chain, sv, g, fill, rot, cin;
   logic [DW-1:0]    w, res;
   logic [LW-1:0]    amt;
   logic [1:0]       cls;
   logic [2:0]       mode;
   logic [TAG_W-1:0] tag;
   int               ps, pd;

   function automatic logic [DW-1:0] bit_rev(input logic [DW-1:0] x);
      logic [DW-1:0] r;
      for (int i = 0; i < DW; i++) r[i] = x[DW-1-i];
      return r;
   endfunction

   always_comb begin
      v_d     = v_q;
      mw_d    = mw_q;
      mamt_d  = mamt_q;
      mcls_d  = mcls_q;
      mmode_d = mmode_q;
      mtag_d  = mtag_q;
      mg_d    = mg_q;
      mfill_d = mfill_q;
      mrot_d  = mrot_q;
      mcin_d  = mcin_q;
      dout_d  = dout_q;
      cout_d  = cout_q;
      otag_d  = otag_q;
      ld      = '0;
      sv      = 1'b0;
      g       = 1'b0;
      fill    = 1'b0;
      rot     = 1'b0;
      cin     = 1'b0;
      w       = '0;
      res     = '0;
      amt     = '0;
      cls     = C_ZERO;
      mode    = M_LSL;
      tag     = '0;
      ps      = 0;
      pd      = 0;

      // a stage loads when empty or when everything downstream can move
      chain = OUT_READY;
      for (int s = STAGES - 1; s >= 0; s--) begin
         ld[s] = !v_q[s] || chain;
         chain = ld[s];
      end
      in_rdy = !FLUSH && ld[0];

      for (int s = 0; s < STAGES; s++) begin
         ps = (s > 0) ? s - 1 : 0;
         pd = (s < MID) ? s : MID - 1;
         if (s == 0) begin
            sv   = IN_VALID && in_rdy;
            mode = MODE;
            cin  = CIN;
            tag  = IN_TAG;
            if (SHAMT == '0)       cls = C_ZERO;
            else if (SHAMT < DW_A) cls = C_LT;
            else if (SHAMT == DW_A) cls = C_EQ;
            else                   cls = 2'd3;
            w    = (MODE == M_LSL) ? bit_rev(DIN) : DIN;
            fill = (MODE == M_ASR) && DIN[DW-1];
            rot  = (MODE == M_ROR);
            g    = 1'b0;
            // out-of-range shifts pass the operand through; the final stage fixes them up
            amt  = (MODE <= M_ROR && cls != C_ZERO && (rot || cls == C_LT)) ? SHAMT[LW-1:0] : '0;
         end else begin
            sv   = v_q[ps];
            mode = mmode_q[ps];
            cin  = mcin_q[ps];
            tag  = mtag_q[ps];
            cls  = mcls_q[ps];
            w    = mw_q[ps];
            fill = mfill_q[ps];
            rot  = mrot_q[ps];
            g    = mg_q[ps];
            amt  = mamt_q[ps];
         end

         // g tracks the last bit shifted out, which is the carry for in-range shifts
         for (int i = 0; i < LW; i++) begin
            if (i >= s * BASE && (i < (s + 1) * BASE || s == STAGES - 1) && amt[i]) begin
               g = w[(1 << i) - 1];
               if (rot) w = (w >> (1 << i)) | (w << (DW - (1 << i)));
               else     w = (w >> (1 << i)) | (fill ? ~({DW{1'b1}} >> (1 << i)) : '0);
            end
         end

         v_d[s] = FLUSH ? 1'b0 : (ld[s] ? sv : v_q[s]);

         if (ld[s] && sv && !FLUSH) begin
            if (s == STAGES - 1) begin
               res    = (mode == M_LSL) ? bit_rev(w) : w;
               dout_d = res;
               cout_d = cin;
               otag_d = tag;
               if (mode == M_RRX) begin
                  dout_d = {cin, res[DW-1:1]};
                  cout_d = res[0];
               end else if (mode <= M_ROR && cls != C_ZERO) begin
                  case (mode)
                     M_LSL, M_LSR: begin
                        if (cls == C_LT) cout_d = g;
                        else begin
                           dout_d = '0;
                           cout_d = (cls == C_EQ) && ((mode == M_LSL) ? res[0] : res[DW-1]);
                        end
                     end
                     M_ASR: begin
                        if (cls == C_LT) cout_d = g;
                        else begin
                           dout_d = {DW{res[DW-1]}};
                           cout_d = res[DW-1];
                        end
                     end
                     default: cout_d = res[DW-1];
                  endcase
               end
            end else begin
               mw_d[pd]    = w;
               mamt_d[pd]  = amt;
               mcls_d[pd]  = cls;
               mmode_d[pd] = mode;
               mtag_d[pd]  = tag;
               mg_d[pd]    = g;
               mfill_d[pd] = fill;
               mrot_d[pd]  = rot;
               mcin_d[pd]  = cin;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         v_q     <= '0;
         dout_q  <= '0;
         cout_q  <= 1'b0;
         otag_q  <= '0;
         mg_q    <= '0;
         mfill_q <= '0;
         mrot_q  <= '0;
         mcin_q  <= '0;
         for (int s = 0; s < MID; s++) begin
            mw_q[s]    <= '0;
            mamt_q[s]  <= '0;
            mcls_q[s]  <= '0;
            mmode_q[s] <= '0;
            mtag_q[s]  <= '0;
         end
      end else begin
         v_q     <= v_d;
         dout_q  <= dout_d;
         cout_q  <= cout_d;
         otag_q  <= otag_d;
         mg_q    <= mg_d;
         mfill_q <= mfill_d;
         mrot_q  <= mrot_d;
         mcin_q  <= mcin_d;
         mw_q    <= mw_d;
         mamt_q  <= mamt_d;
         mcls_q  <= mcls_d;
         mmode_q <= mmode_d;
         mtag_q  <= mtag_d;
      end
   end

   assign IN_READY  = in_rdy;
   assign OUT_VALID = v_q[STAGES-1];
   assign DOUT      = dout_q;
   assign COUT      = cout_q;
   assign OUT_TAG   = otag_q;

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - scoreboard bench for shift_pipe with a behavioural shift model
module tb_shift_pipe;
   localparam int DW = 32, AW = 8, STAGES = 2, TAG_W = 4;

   logic             CLK = 1'b0, nRST = 1'b0, FLUSH = 1'b0, IN_VALID = 1'b0, CIN = 1'b0, OUT_READY = 1'b0;
   logic             IN_READY, OUT_VALID, COUT;
   logic [DW-1:0]    DIN = '0, DOUT;
   logic [AW-1:0]    SHAMT = '0;
   logic [2:0]       MODE = '0;
   logic [TAG_W-1:0] IN_TAG = '0, OUT_TAG;

   always #5 CLK = ~CLK;

   shift_pipe #(.DW(DW), .AW(AW), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .CLK(CLK), .nRST(nRST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .DIN(DIN), .SHAMT(SHAMT), .MODE(MODE), .CIN(CIN), .IN_TAG(IN_TAG),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DOUT(DOUT), .COUT(COUT), .OUT_TAG(OUT_TAG)
   );

   typedef struct packed { logic [TAG_W-1:0] tag; logic [DW-1:0] d; logic c; } exp_t;
   typedef struct packed { logic [31:0] din; logic [7:0] n; logic [2:0] mode; logic cin; logic [31:0] ed; logic ec; } vec_t;

   exp_t sb[$];
   int checks = 0, errors = 0, cyc = 0, n_acc = 0, n_out = 0;
   int acc_cyc[16];
   bit lat_on = 1'b0, prev_stall = 1'b0;
   logic [DW-1:0] prev_d;
   logic prev_c;
   logic [TAG_W-1:0] prev_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic void ref_shift(input logic [DW-1:0] din, input int n, input int mode,
                                     input logic cin, output logic [DW-1:0] d, output logic c);
      int r;
      d = din;
      c = cin;
      if (mode == 4) begin
         d = {cin, din[DW-1:1]};
         c = din[0];
      end else if (mode <= 3 && n != 0) begin
         case (mode)
            0: if (n < DW) begin d = din << n; c = din[DW-n]; end
               else begin d = '0; c = (n == DW) ? din[0] : 1'b0; end
            1: if (n < DW) begin d = din >> n; c = din[n-1]; end
               else begin d = '0; c = (n == DW) ? din[DW-1] : 1'b0; end
            2: if (n < DW) begin d = $signed(din) >>> n; c = din[n-1]; end
               else begin d = {DW{din[DW-1]}}; c = din[DW-1]; end
            default: begin
               r = n % DW;
               if (r == 0) begin d = din; c = din[DW-1]; end
               else begin d = (din >> r) | (din << (DW - r)); c = d[DW-1]; end
            end
         endcase
      end
   endfunction

   task automatic step(input bit iv, input logic [DW-1:0] din, input int n, input int mode,
                       input logic cin, input logic [TAG_W-1:0] tag, input bit ordy, input bit fl,
                       input bit use_exp, input logic [DW-1:0] ed, input logic ec);
      logic [DW-1:0] md;
      logic mc;
      exp_t e;
      IN_VALID = iv; DIN = din; SHAMT = AW'(n); MODE = 3'(mode); CIN = cin;
      IN_TAG = tag; OUT_READY = ordy; FLUSH = fl;
      #2;
      if (prev_stall) begin
         check("hold_valid", OUT_VALID, 1);
         check("hold_dout", DOUT, prev_d);
         check("hold_cout", COUT, prev_c);
         check("hold_tag", OUT_TAG, prev_t);
      end
      if (fl) begin
         if (iv) check("flush_in_ready", IN_READY, 0);
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (OUT_VALID && OUT_READY) begin
            n_out++;
            if (sb.size() == 0) check("spurious_out", OUT_VALID, 0);
            else begin
               e = sb.pop_front();
               check("dout", DOUT, e.d);
               check("cout", COUT, e.c);
               check("tag", OUT_TAG, e.tag);
               if (lat_on) check("latency", cyc - acc_cyc[e.tag], STAGES);
            end
         end
         if (iv && IN_READY) begin
            n_acc++;
            acc_cyc[tag] = cyc;
            ref_shift(din, n, mode, cin, md, mc);
            sb.push_back({tag, use_exp ? ed : md, use_exp ? ec : mc});
         end
         prev_stall = OUT_VALID && !OUT_READY;
         prev_d = DOUT; prev_c = COUT; prev_t = OUT_TAG;
      end
      @(posedge CLK);
      #2;
      cyc++;
   endtask

   task automatic idle(input bit ordy);
      step(1'b0, '0, 0, 0, 1'b0, '0, ordy, 1'b0, 1'b0, '0, 1'b0);
   endtask

   function automatic int pick_n();
      case ($urandom_range(0, 8))
         0: return 0;
         1: return 1;
         2: return 31;
         3: return 32;
         4: return 33;
         5: return 63;
         6: return 64;
         7: return 255;
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   vec_t dir[11];
   int a0, o0;

   initial begin
      dir = '{
         '{32'h8000_0001, 8'd0,   3'd0, 1'b1, 32'h8000_0001, 1'b1},
         '{32'h8000_0001, 8'd1,   3'd0, 1'b1, 32'h0000_0002, 1'b1},
         '{32'h8000_0001, 8'd32,  3'd0, 1'b1, 32'h0000_0000, 1'b1},
         '{32'h8000_0001, 8'd33,  3'd0, 1'b1, 32'h0000_0000, 1'b0},
         '{32'h8000_0003, 8'd1,   3'd1, 1'b0, 32'h4000_0001, 1'b1},
         '{32'h8000_0003, 8'd32,  3'd1, 1'b0, 32'h0000_0000, 1'b1},
         '{32'h8000_0003, 8'd4,   3'd2, 1'b0, 32'hF800_0000, 1'b0},
         '{32'h8000_0003, 8'd200, 3'd2, 1'b0, 32'hFFFF_FFFF, 1'b1},
         '{32'h0000_00F1, 8'd4,   3'd3, 1'b0, 32'h1000_000F, 1'b0},
         '{32'h0000_00F1, 8'd64,  3'd3, 1'b0, 32'h0000_00F1, 1'b0},
         '{32'h0000_00F1, 8'd9,   3'd4, 1'b1, 32'h8000_0078, 1'b1}
      };

      repeat (2) @(posedge CLK);
      #2;
      check("rst_out_valid", OUT_VALID, 0);
      check("rst_dout", DOUT, 0);
      check("rst_cout", COUT, 0);
      check("rst_out_tag", OUT_TAG, 0);
      nRST = 1'b1;
      #1;
      check("rst_in_ready", IN_READY, 1);
      @(posedge CLK);
      #2;

      for (int i = 0; i < 11; i++)
         step(1'b1, dir[i].din, int'(dir[i].n), int'(dir[i].mode), dir[i].cin, 4'(i),
              1'b1, 1'b0, 1'b1, dir[i].ed, dir[i].ec);
      repeat (4) idle(1'b1);
      check("dir_drain", sb.size(), 0);

      lat_on = 1'b1;
      o0 = n_out;
      for (int t = 0; t < 8; t++)
         step(1'b1, $urandom, pick_n(), int'($urandom_range(0, 7)), 1'($urandom),
              4'(t), 1'b1, 1'b0, 1'b0, '0, 1'b0);
      repeat (4) idle(1'b1);
      lat_on = 1'b0;
      check("b2b_count", n_out - o0, 8);

      a0 = n_acc;
      o0 = n_out;
      for (int t = 0; t < 5; t++)
         step(1'b1, $urandom, pick_n(), int'($urandom_range(0, 7)), 1'($urandom),
              4'(t + 8), 1'b0, 1'b0, 1'b0, '0, 1'b0);
      check("bp_accepts", n_acc - a0, 2);
      check("bp_in_ready", IN_READY, 0);
      repeat (4) idle(1'b1);
      check("bp_drain", n_out - o0, 2);

      step(1'b1, 32'h1234_5678, 3, 1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 32'h8765_4321, 5, 0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 32'hDEAD_BEEF, 7, 3, 1'b0, 4'hC, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      check("flush_out_valid", OUT_VALID, 0);
      o0 = n_out;
      repeat (6) idle(1'b1);
      check("flush_no_out", n_out - o0, 0);

      step(1'b1, 32'hFFFF_FFFF, 0, 0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 32'hFFFF_FFFF, 0, 0, 1'b1, 4'hD, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      #1 nRST = 1'b0;
      #1;
      check("arst_out_valid", OUT_VALID, 0);
      check("arst_dout", DOUT, 0);
      check("arst_cout", COUT, 0);
      check("arst_out_tag", OUT_TAG, 0);
      sb.delete();
      prev_stall = 1'b0;
      @(posedge CLK);
      #1 nRST = 1'b1;
      #1;
      o0 = n_out;
      repeat (5) idle(1'b1);
      check("arst_no_out", n_out - o0, 0);

      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 3) != 0, $urandom, pick_n(), int'($urandom_range(0, 7)),
              1'($urandom), 4'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
              1'b0, '0, 1'b0);
      repeat (8) idle(1'b1);
      check("final_drain", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
